// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: gates the TX FIFO serializer enable for one frame at a time,
// counts per-bit strobes to the frame boundary, flags underflow/abort, then enforces an idle gap.
module tx_frame_sequencer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MAX_LEN    = 127,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned IFS_CYCLES = 9600,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [6:0]    frame_len,
  input  logic          abort,
  input  logic [CW-1:0] fifo_count,
  input  logic          iq_rate,
  output logic          en_iq,
  output logic          busy,
  output logic          done,
  output logic          err_underflow,
  output logic          err_len,
  output logic [9:0]    bits_left
);

  localparam int unsigned GW = (IFS_CYCLES > 1) ? $clog2(IFS_CYCLES) : 1;
  localparam logic [GW-1:0] GapLoad = GW'(IFS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitData, StTx, StGap} state_e;

  state_e        state_q, state_d;
  logic [6:0]    len_q, len_d;
  logic [9:0]    bits_q, bits_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_d, err_len_d, uf_q, uf_d;
  logic          en_q, busy_q, done_q, err_len_q;

  logic          len_ok, fill_ok, strobe, underflow;
  logic [31:0]   need;

  assign len_ok    = (frame_len != 7'd0) && (32'(frame_len) <= MAX_LEN);
  assign need      = (32'(len_q) < PREFILL) ? 32'(len_q) : PREFILL;
  assign fill_ok   = 32'(fifo_count) >= need;
  // Strobes with nothing left to send are ignored so the counter never wraps.
  assign strobe    = iq_rate && (bits_q != 10'd0);
  // Last bit of a byte leaves the serializer with no next byte queued.
  assign underflow = strobe && (bits_q[2:0] == 3'd1) && (bits_q > 10'd1) && (fifo_count == '0);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bits_d    = bits_q;
    gap_d     = gap_q;
    uf_d      = uf_q;
    done_d    = 1'b0;
    err_len_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        bits_d = 10'd0;
        if (start) begin
          if (len_ok) begin
            len_d   = frame_len;
            bits_d  = {frame_len, 3'b000};
            uf_d    = 1'b0;
            state_d = StWaitData;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      StWaitData: begin
        if (abort) begin
          bits_d  = 10'd0;
          gap_d   = GapLoad;
          state_d = StGap;
        end else if (fill_ok) begin
          state_d = StTx;
        end
      end
      StTx: begin
        // Priority: underflow reports even alongside abort; abort suppresses done.
        if (underflow) begin
          uf_d    = 1'b1;
          bits_d  = 10'd0;
          gap_d   = GapLoad;
          state_d = StGap;
        end else if (abort) begin
          bits_d  = 10'd0;
          gap_d   = GapLoad;
          state_d = StGap;
        end else if (strobe) begin
          bits_d = bits_q - 10'd1;
          if (bits_q == 10'd1) begin
            done_d  = 1'b1;
            gap_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= 7'd0;
      bits_q    <= 10'd0;
      gap_q     <= '0;
      uf_q      <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      bits_q    <= bits_d;
      gap_q     <= gap_d;
      uf_q      <= uf_d;
      en_q      <= (state_d == StTx);
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
      err_len_q <= err_len_d;
    end
  end

  assign en_iq         = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_underflow = uf_q;
  assign err_len       = err_len_q;
  assign bits_left     = bits_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: directed corner frames plus randomized frames, each checked
// against timing and bit counts derived arithmetically from frame length and event position.
module tb_tx_frame_sequencer;

  localparam int unsigned Depth   = 64;
  localparam int unsigned MaxLen  = 100;
  localparam int unsigned Prefill = 4;
  localparam int unsigned Ifs     = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] frame_len = 7'd0;
  logic       abort = 1'b0;
  logic [6:0] fifo_count = 7'd0;
  logic       iq_rate = 1'b0;
  logic       en_iq, busy, done, err_underflow, err_len;
  logic [9:0] bits_left;

  int unsigned n_checks = 0;
  int unsigned n_errs = 0;

  always #5 clk = ~clk;

  tx_frame_sequencer #(
    .DEPTH     (Depth),
    .MAX_LEN   (MaxLen),
    .PREFILL   (Prefill),
    .IFS_CYCLES(Ifs)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_len    (frame_len),
    .abort        (abort),
    .fifo_count   (fifo_count),
    .iq_rate      (iq_rate),
    .en_iq        (en_iq),
    .busy         (busy),
    .done         (done),
    .err_underflow(err_underflow),
    .err_len      (err_len),
    .bits_left    (bits_left)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inter-frame gap: Ifs cycles of busy after the terminating edge; start/abort have no effect.
  task automatic run_gap(input bit exp_uf);
    int unsigned bad = 0;
    for (int i = 1; i < Ifs; i++) begin
      if (i == 3) begin
        start = 1'b1;
        frame_len = 7'd5;
      end
      if (i == 5) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (busy !== 1'b1 || en_iq !== 1'b0 || done !== 1'b0) bad++;
    end
    tick();
    check("gap_held", bad, 0);
    check("gap_idle_busy", 32'(busy), 0);
    check("gap_start_ignored", 32'(bits_left), 0);
    check("gap_uf_sticky", 32'(err_underflow), 32'(exp_uf));
  endtask

  // One frame. abort_bit/uf_byte = 0 means the event is not injected.
  task automatic frame(input int unsigned len, input int unsigned fill, input int unsigned abort_bit,
                       input int unsigned uf_byte, input bit b2b);
    int unsigned total = len * 8;
    int unsigned need = (len < Prefill) ? len : Prefill;
    int unsigned bad = 0;
    int unsigned dones = 0;
    bit term = 1'b0;
    bit is_uf, is_ab, is_fin;
    fifo_count = 7'(fill);
    frame_len = 7'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_bits", 32'(bits_left), total);
    check("accept_en", 32'(en_iq), 0);
    check("accept_uf_clear", 32'(err_underflow), 0);
    if (fill < need) begin
      for (int i = 0; i < 3; i++) begin
        iq_rate = (i == 1);
        tick();
        iq_rate = 1'b0;
        if (en_iq !== 1'b0 || bits_left != 10'(total)) bad++;
      end
      check("prefill_wait", bad, 0);
      fifo_count = 7'(need);
    end
    tick();
    check("tx_enable", 32'(en_iq), 1);
    bad = 0;
    for (int unsigned k = 1; k <= total && !term; k++) begin
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          if (en_iq !== 1'b1 || bits_left != 10'(total - k + 1)) bad++;
        end
      end
      is_uf  = (uf_byte != 0) && (k == uf_byte * 8);
      is_ab  = (k == abort_bit);
      is_fin = (k == total);
      if (is_uf) fifo_count = 7'd0;
      iq_rate = 1'b1;
      abort = is_ab;
      tick();
      iq_rate = 1'b0;
      abort = 1'b0;
      if (done === 1'b1) dones++;
      if (is_uf || is_ab || is_fin) begin
        term = 1'b1;
        check("end_en", 32'(en_iq), 0);
        check("end_bits", 32'(bits_left), 0);
        check("end_busy", 32'(busy), 1);
        check("end_uf", 32'(err_underflow), 32'(is_uf));
        check("done_count", dones, (is_fin && !is_uf && !is_ab) ? 1 : 0);
      end else if (en_iq !== 1'b1 || bits_left != 10'(total - k)) begin
        bad++;
      end
    end
    check("tx_progress", bad, 0);
    fifo_count = 7'(Depth);
    run_gap(err_underflow);
  endtask

  task automatic bad_len(input int unsigned v);
    frame_len = 7'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("len_err_pulse", 32'(err_len), 1);
    check("len_busy", 32'(busy), 0);
    tick();
    check("len_err_clear", 32'(err_len), 0);
  endtask

  initial begin
    int unsigned len, ab, uf;
    reset = 1'b1;
    tick();
    tick();
    check("rst_en", 32'(en_iq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_uf", 32'(err_underflow), 0);
    check("rst_errlen", 32'(err_len), 0);
    check("rst_bits", 32'(bits_left), 0);
    reset = 1'b0;

    // Mid-frame reset of a 10-byte frame.
    fifo_count = 7'(Depth);
    frame_len = 7'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mr_en_before", 32'(en_iq), 1);
    repeat (20) begin
      iq_rate = 1'b1;
      tick();
    end
    iq_rate = 1'b0;
    check("mr_bits_before", 32'(bits_left), 60);
    reset = 1'b1;
    tick();
    check("mr_en", 32'(en_iq), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_bits", 32'(bits_left), 0);
    check("mr_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_idle", 32'(busy), 0);

    frame(64, 64, 0, 0, 1'b1);   // nominal, back-to-back strobes
    frame(20, 2, 0, 0, 1'b0);    // prefill wait
    frame(8, 64, 0, 3, 1'b0);    // underflow at byte 3 boundary
    frame(5, 64, 0, 0, 1'b0);    // clears sticky underflow
    bad_len(0);
    bad_len(127);
    bad_len(MaxLen + 1);
    frame(16, 64, 37, 0, 1'b0);  // abort mid-frame
    frame(8, 64, 24, 3, 1'b1);   // abort with underflow
    frame(2, 64, 16, 0, 1'b1);   // abort wins over final strobe
    frame(1, 0, 0, 0, 1'b0);     // shortest frame, need = 1
    frame(MaxLen, 64, 0, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, MaxLen);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len * 8) : 0;
      uf  = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
      frame(len, $urandom_range(0, len), ab, uf, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Transmit frame sequencer for the Zigbee TX path. It owns the `en_IQ` enable of the TX FIFO serializer. It accepts a frame-start command with a byte length and waits until the FIFO holds enough bytes to cover the frame or the prefill threshold. It then enables serialization, counts the per-bit `IQ_rate` strobes, stops exactly at the frame boundary and enforces an inter-frame gap. Underflow and abort are detected and reported. Up the chain it sits between the APB/MAC control logic and the FIFO serializer.

## Interface
- `DEPTH`, 64: TX FIFO depth in bytes; sets the `fifo_count` width to $clog2(DEPTH+1).
- `MAX_LEN`, 127: maximum frame length in bytes (PHR limit).
- `PREFILL`, 4: minimum bytes present before TX starts when `frame_len` > `PREFILL`.
- `IFS_CYCLES`, 9600: idle gap after each frame, in clk cycles (192 µs at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame request; only accepted in IDLE.
- `frame_len` in 7: frame length in bytes, sampled when `start` is accepted.
- `abort` in 1: level; terminates any active frame.
- `fifo_count` in $clog2(DEPTH+1): bytes currently stored in the FIFO.
- `iq_rate` in 1: one-cycle strobe from the serializer, one per bit shifted out.
- `en_iq` out 1: serializer enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `err_underflow` out 1: sticky; set on underflow, cleared by the next accepted `start`.
- `err_len` out 1: one-cycle pulse when `start` is rejected for `frame_len` = 0 or `frame_len` > `MAX_LEN`.
- `bits_left` out 10: remaining bits of the current frame; 0 when idle.

## Operation
- **States:** IDLE, WAIT_DATA, TX, GAP.
- **IDLE**
  - `start` with a valid `frame_len`: latch `len`, load `bits_left` = `len`*8, go to WAIT_DATA.
  - `start` with an invalid `frame_len`: pulse `err_len` and stay in IDLE.
- **WAIT_DATA**
  - Go to TX when `fifo_count` >= min(`len`, `PREFILL`).
  - `en_iq` is asserted from the first TX cycle.
- **TX**
  - `en_iq` = 1.
  - Each `iq_rate` strobe decrements `bits_left`.
  - If a strobe arrives with `bits_left` = 1: `bits_left` becomes 0, `en_iq` drops the next cycle, `done` pulses the next cycle, go to GAP.
- **Underflow**
  - Detected in TX on an `iq_rate` strobe where `bits_left`[2:0] = 1, `bits_left` > 1 and `fifo_count` = 0. This is a byte boundary with no next byte available.
  - Response: set `err_underflow`, drop `en_iq`, clear `bits_left`, go to GAP. No `done`.
- **GAP**
  - `en_iq` = 0.
  - Counter runs from `IFS_CYCLES`-1 down to 0, then goes to IDLE.
  - `start` is ignored during GAP; it is not queued.
- **abort**
  - In WAIT_DATA or TX: go to GAP the next cycle, drop `en_iq`, clear `bits_left`, no `done`.
  - In IDLE or GAP: no effect.
- **Simultaneous events**
  - `abort` wins over a final-bit strobe (no `done`).
  - Underflow and `abort` in the same cycle: `err_underflow` is set and the block goes to GAP.
- **reset**
  - Forces IDLE from any state on the next edge.
  - Mid-frame reset drops `en_iq` immediately.
- **Arithmetic:** `bits_left` is 10 bits unsigned (127*8 = 1016 fits). It never wraps below 0; strobes seen with `bits_left` = 0 are ignored.

## Timing
- Reset values: `en_iq` = 0, `busy` = 0, `done` = 0, `err_underflow` = 0, `err_len` = 0, `bits_left` = 0, state IDLE, gap counter 0.
- All outputs are registered.
- `start` accepted in cycle N:
  - `busy` = 1 at N+1.
  - If the FIFO is already sufficiently filled: TX and `en_iq` = 1 at N+2.
- Final strobe in cycle M: `en_iq` = 0 and `done` = 1 at M+1. `busy` stays 1 until GAP expires, i.e. IDLE at M+1+`IFS_CYCLES`.
- `err_len` pulses one cycle after the rejected `start`.
- `iq_rate` is a one-cycle strobe. Back-to-back strobes (one every cycle) must each be counted.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-TX of a 10-byte frame -> `en_iq` = 0 and `busy` = 0 the cycle after, `bits_left` = 0, no `done`.
- **Nominal frame:** `fifo_count` = 64 preloaded, `start` with `frame_len` = 64 -> `en_iq` high 2 cycles later; exactly 512 strobes counted; `done` pulses once; `en_iq` low the cycle after the 512th strobe; `busy` low `IFS_CYCLES` cycles later.
- **Prefill wait:** `fifo_count` = 2, `start` with `frame_len` = 20, `PREFILL` = 4 -> stays in WAIT_DATA (`en_iq` = 0) until `fifo_count` = 4, then `en_iq` = 1.
- **Underflow:** `frame_len` = 8, `fifo_count` forced to 0 after byte 3 -> `err_underflow` = 1 at the byte-3 boundary strobe (`bits_left` 41 -> 40), `en_iq` = 0 the next cycle, no `done`; next valid `start` clears `err_underflow`.
- **Length check:** `start` with `frame_len` = 0, then with `frame_len` = 127 in IDLE and `MAX_LEN` = 100 -> `err_len` pulses twice, `busy` stays 0.
- **Abort and ignored start:** `abort` at bit 37 of a 16-byte frame -> GAP next cycle, `bits_left` = 0, no `done`; `start` issued during GAP is ignored and IDLE is reached after `IFS_CYCLES`.
